// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller.
// Decodes load-use bubbles, taken-branch flushes and data-memory wait/freeze from a small
// RUN / MEMWAIT / ABORT state machine. Outputs are combinational; state and counters are
// registered. A memory access that never acknowledges is aborted after MEM_TIMEOUT wait
// cycles and latches a sticky error flag.
module hazard_stall_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_Rs_i,
  input  logic [4:0]  ID_Rt_i,
  input  logic        ID_UsesRt_i,
  input  logic [4:0]  EX_Rt_i,
  input  logic        EX_MemRead_i,
  input  logic        ID_BranchTaken_i,
  input  logic        MemReq_i,
  input  logic        MemAck_i,
  output logic        IsHazzard_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFFlush_o,
  output logic        Freeze_o,
  output logic        MemErr_o,
  output logic [15:0] StallCnt_o
);

  typedef enum logic [1:0] {StRun, StMemWait, StAbort} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_miss;

  assign load_use = EX_MemRead_i & (EX_Rt_i != 5'd0) &
                    ((EX_Rt_i == ID_Rs_i) | (ID_UsesRt_i & (EX_Rt_i == ID_Rt_i)));
  assign mem_miss = MemReq_i & ~MemAck_i;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    IsHazzard_o = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFFlush_o   = 1'b0;
    Freeze_o    = 1'b0;

    if (rst_i) begin
      // Register reset happens at the edge; here only the controls are forced.
      IsHazzard_o = 1'b1;
      IFFlush_o   = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_miss) begin
            Freeze_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            state_d     = StMemWait;
            wait_cnt_d  = 8'd1;
          end else if (load_use) begin
            IsHazzard_o = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
          end else if (ID_BranchTaken_i) begin
            IFFlush_o = 1'b1;
          end
        end
        StMemWait: begin
          if (MemAck_i) begin
            // Ack releases the freeze this cycle; ack beats a coincident timeout.
            state_d    = StRun;
            wait_cnt_d = 8'd0;
            if (load_use) begin
              IsHazzard_o = 1'b1;
              PCWrite_o   = 1'b0;
              IFIDWrite_o = 1'b0;
            end else if (ID_BranchTaken_i) begin
              IFFlush_o = 1'b1;
            end
          end else begin
            Freeze_o    = 1'b1;
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            if (wait_cnt_q == MEM_TIMEOUT) begin
              state_d    = StAbort;
              mem_err_d  = 1'b1;
              wait_cnt_d = 8'd0;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        StAbort: begin
          // One-cycle squash of the stalled instruction after a memory timeout.
          IsHazzard_o = 1'b1;
          IFFlush_o   = 1'b1;
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          state_d     = StRun;
        end
        default: begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Saturating stall counter; reset cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rst_i && !PCWrite_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr_o   = mem_err_q;
  assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven bench for hazard_stall_ctrl with MEM_TIMEOUT=4.
// Each table row is one clock cycle: inputs applied after the rising edge, outputs
// compared on the falling edge. Counter saturation is exercised by a long held stall.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, br_taken, mem_req, mem_ack;
  logic        is_haz, pc_write, ifid_write, if_flush, freeze, mem_err;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT(8'd4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ID_Rs_i         (id_rs),
    .ID_Rt_i         (id_rt),
    .ID_UsesRt_i     (id_uses_rt),
    .EX_Rt_i         (ex_rt),
    .EX_MemRead_i    (ex_mem_read),
    .ID_BranchTaken_i(br_taken),
    .MemReq_i        (mem_req),
    .MemAck_i        (mem_ack),
    .IsHazzard_o     (is_haz),
    .PCWrite_o       (pc_write),
    .IFIDWrite_o     (ifid_write),
    .IFFlush_o       (if_flush),
    .Freeze_o        (freeze),
    .MemErr_o        (mem_err),
    .StallCnt_o      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urt;
    logic [4:0]  exrt;
    logic        mrd;
    logic        br;
    logic        req;
    logic        ack;
    logic        haz;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        frz;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urt, input logic [4:0] exrt, input logic mrd,
                              input logic br, input logic req, input logic ack,
                              input logic haz, input logic pcw, input logic ifw,
                              input logic fl, input logic frz, input logic err,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = r;  v.rs = rs;   v.rt = rt;   v.urt = urt; v.exrt = exrt;
    v.mrd = mrd; v.br = br;  v.req = req; v.ack = ack;
    v.haz = haz; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.frz = frz; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt; ex_rt = v.exrt;
    ex_mem_read = v.mrd; br_taken = v.br; mem_req = v.req; mem_ack = v.ack;
  endtask

  vec_t tbl[$];

  initial begin
    //             rst rs  rt  urt exrt mrd br req ack | haz pcw ifw fl frz err cnt
    // Reset with hostile inputs: forced controls, no counting.
    tbl.push_back(mk(1, 5, 0, 0, 5, 1, 1, 1, 0,   1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 5, 1, 1, 1, 0,   1, 0, 0, 1, 0, 0, 0));
    // Load-use on Rs: one bubble, then idle.
    tbl.push_back(mk(0, 5, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 5, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1));
    // $zero destination, and Rt match without Rt use: no stall.
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 7, 0, 7, 1, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1));
    // Same with Rt used: stall.
    tbl.push_back(mk(0, 3, 7, 1, 7, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1));
    // Taken branch flush.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0, 2));
    // Miss, ack three cycles later.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 5));
    // Timeout: miss, 4 MEMWAIT cycles, ABORT, sticky error.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 6));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 7));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 8));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 9));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 1, 10));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 11));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1, 11));
    // Ack coincides with timeout: ack wins, no error.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 4));
    // Miss + load-use + branch: freeze only, then bubble in ack cycle, then flush.
    tbl.push_back(mk(0, 5, 2, 0, 5, 1, 1, 1, 0,   0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 5, 2, 0, 5, 1, 1, 1, 0,   0, 0, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, 5, 2, 0, 5, 1, 1, 1, 1,   1, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 5, 2, 0, 5, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0, 7));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 7));
    // Reset mid-MEMWAIT: back to RUN, counter cleared, no error.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 7));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 8));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 9));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0));
    // Stray ack in RUN is ignored.
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0));

    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk("IsHazzard", i, {15'd0, is_haz},     {15'd0, tbl[i].haz});
      chk("PCWrite",   i, {15'd0, pc_write},   {15'd0, tbl[i].pcw});
      chk("IFIDWrite", i, {15'd0, ifid_write}, {15'd0, tbl[i].ifw});
      chk("IFFlush",   i, {15'd0, if_flush},   {15'd0, tbl[i].fl});
      chk("Freeze",    i, {15'd0, freeze},     {15'd0, tbl[i].frz});
      chk("MemErr",    i, {15'd0, mem_err},    {15'd0, tbl[i].err});
      chk("StallCnt",  i, stall_cnt,           tbl[i].cnt);
      @(posedge clk);
      #1;
    end

    // Saturation: hold a load-use stall so every cycle counts.
    apply(mk(0, 5, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("StallCntNearMax", 1000, stall_cnt, 16'hFFFE);
    @(negedge clk);
    chk("StallCntMax", 1001, stall_cnt, 16'hFFFF);
    @(negedge clk);
    chk("StallCntSat", 1002, stall_cnt, 16'hFFFF);
    chk("SatPCWrite", 1002, {15'd0, pc_write}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8'd200, maximum MEMWAIT cycles before abort.
REQ-002 Port: clk_i  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 Port: ID_Rs_i, ID_Rt_i  in  5 each  source register numbers of the instruction in ID.
REQ-005 Port: ID_UsesRt_i  in  1  ID instruction reads Rt as a source.
REQ-006 Port: EX_Rt_i  in  5  destination register of the instruction in EX.
REQ-007 Port: EX_MemRead_i  in  1  instruction in EX is a load.
REQ-008 Port: ID_BranchTaken_i  in  1  branch or jump resolved taken in ID.
REQ-009 Port: MemReq_i  in  1  MEM stage has a data-memory access this cycle.
REQ-010 Port: MemAck_i  in  1  data memory completes the access this cycle.
REQ-011 Port: IsHazzard_o  out  1  zeroes ID control signals through the control mux (bubble into ID/EX).
REQ-012 Port: PCWrite_o, IFIDWrite_o  out  1 each  PC and IF/ID register write enables.
REQ-013 Port: IFFlush_o  out  1  IF/ID register loads a NOP.
REQ-014 Port: Freeze_o  out  1  holds ID/EX, EX/MEM and MEM/WB registers.
REQ-015 Port: MemErr_o  out  1  sticky memory-timeout flag.
REQ-016 Port: StallCnt_o  out  16  saturating count of cycles with PCWrite_o=0.

Function
REQ-017 States: RUN, MEMWAIT, ABORT; state and counters are registered, outputs decode combinationally from state and inputs.
REQ-018 LoadUse = EX_MemRead_i & (EX_Rt_i!=0) & ((EX_Rt_i==ID_Rs_i) | (ID_UsesRt_i & (EX_Rt_i==ID_Rt_i))).
REQ-019 MemMiss = MemReq_i & ~MemAck_i.
REQ-020 RUN, MemMiss=1: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, IsHazzard_o=0, IFFlush_o=0; next state MEMWAIT, wait counter loads 1.
REQ-021 RUN, MemMiss=0, LoadUse=1: IsHazzard_o=1, PCWrite_o=0, IFIDWrite_o=0, IFFlush_o=0, Freeze_o=0; stay RUN; exactly one bubble per load-use pair.
REQ-022 RUN, neither condition, ID_BranchTaken_i=1: IFFlush_o=1, PCWrite_o=1, IFIDWrite_o=1.
REQ-023 RUN idle: PCWrite_o=IFIDWrite_o=1, all other controls 0.
REQ-024 Priority MemMiss > LoadUse > BranchTaken; a suppressed branch flush is not remembered, because the held IF/ID re-presents the branch next cycle.
REQ-025 MEMWAIT: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0 and the counter increments each cycle MemAck_i=0.
REQ-026 MEMWAIT, MemAck_i=1: in the same cycle Freeze_o=0 and PCWrite_o=IFIDWrite_o=1 (LoadUse/branch rules of RUN apply that cycle); next state RUN.
REQ-027 MEMWAIT, counter==MEM_TIMEOUT with MemAck_i=0: next state ABORT and MemErr_o set.
REQ-028 ABORT (one cycle): Freeze_o=0, IsHazzard_o=1, IFFlush_o=1, PCWrite_o=0; next state RUN.
REQ-029 MemAck_i and the timeout in the same cycle: the ack wins, no error.
REQ-030 MemErr_o remains 1 until reset.
REQ-031 StallCnt_o increments in every cycle PCWrite_o=0 and saturates at 16'hFFFF without wrapping.
REQ-032 MemReq_i/MemAck_i outside RUN/MEMWAIT are ignored.

Reset
REQ-033 rst_i=1 at an edge: state->RUN, wait counter=0, MemErr_o=0, StallCnt_o=0.
REQ-034 While rst_i=1: IsHazzard_o=1, IFFlush_o=1, PCWrite_o=0, IFIDWrite_o=0, Freeze_o=0, regardless of other inputs; StallCnt_o does not count these cycles.
REQ-035 Reset asserted in MEMWAIT or ABORT aborts the sequence with no MemErr_o set; the first cycle after release is RUN.

Verification
REQ-036 EX lw Rt=5, ID add Rs=5: one cycle IsHazzard_o=1, PCWrite_o=0, IFIDWrite_o=0; the next cycle (EX_MemRead_i=0) is idle; StallCnt_o=1.
REQ-037 EX lw Rt=0, ID Rs=0 -> no stall; EX lw Rt=7, ID Rt=7 with ID_UsesRt_i=0 -> no stall.
REQ-038 MemReq_i=1 with MemAck_i arriving 3 cycles later -> Freeze_o=1 for 3 cycles, released in the ack cycle; StallCnt_o=3.
REQ-039 MemReq_i held with no ack for MEM_TIMEOUT=4 -> MEMWAIT 4 cycles, one ABORT cycle (IFFlush_o=1, IsHazzard_o=1), MemErr_o=1 until rst_i.
REQ-040 MemMiss, LoadUse and ID_BranchTaken_i in the same RUN cycle -> only Freeze_o path (IFFlush_o=0, IsHazzard_o=0); after the ack, LoadUse bubble, then flush.
REQ-041 rst_i=1 mid-MEMWAIT -> next cycle RUN, StallCnt_o=0, MemErr_o=0; StallCnt_o forced near 16'hFFFE saturates at 16'hFFFF.
